// File: rtl/exu_ctrl.sv
// Execute-stage sequencing controller: single-entry op buffer between IDU and WBU/LSU.
// Optional EXU_PERF_EN adds perf_ops/perf_busy event counters.
module exu_ctrl #(
  parameter int unsigned EXEC_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_alu_srca,
  input  logic [1:0]  in_alu_srcb,
  input  logic [3:0]  in_alu_ctrl,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rd,
  input  logic        in_wen,
  output logic [1:0]  exu_alu_srca,
  output logic [1:0]  exu_alu_srcb,
  output logic [3:0]  exu_alu_ctrl,
  output logic [31:0] exu_data_reg1,
  output logic [31:0] exu_data_reg2,
  output logic [31:0] exu_ext_imm,
  output logic [31:0] exu_pc_val,
  input  logic [31:0] exu_alu_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic [31:0] out_pc,
  output logic        out_illegal,
  output logic        busy
`ifdef EXU_PERF_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_busy
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(EXEC_LAT - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt;
  logic [1:0]  r_srca, r_srcb;
  logic [3:0]  r_ctrl;
  logic [31:0] r_rs1, r_rs2, r_imm, r_pc, r_res;
  logic [4:0]  r_rd;
  logic        r_wen, r_illegal;
  logic        w_accept, w_illegal;

  assign in_ready  = ~flush & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
  assign w_accept  = in_valid & in_ready;
  assign w_illegal = (in_alu_srca == 2'b11) | (in_alu_srcb == 2'b11);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXEC;
      EXEC:    if (r_cnt == '0) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = w_accept ? EXEC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // accept is impossible while in EXEC, so the two branches never compete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_srca    <= '0;
      r_srcb    <= '0;
      r_ctrl    <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_rd      <= '0;
      r_wen     <= 1'b0;
      r_illegal <= 1'b0;
      r_res     <= '0;
    end else if (w_accept) begin
      r_cnt     <= LAT_M1;
      r_srca    <= (in_alu_srca == 2'b11) ? 2'b00 : in_alu_srca;
      r_srcb    <= (in_alu_srcb == 2'b11) ? 2'b00 : in_alu_srcb;
      r_ctrl    <= in_alu_ctrl;
      r_rs1     <= in_rs1;
      r_rs2     <= in_rs2;
      r_imm     <= in_imm;
      r_pc      <= in_pc;
      r_rd      <= in_rd;
      r_wen     <= in_wen & ~w_illegal;
      r_illegal <= w_illegal;
    end else if ((r_state == EXEC) && !flush) begin
      if (r_cnt != '0) r_cnt <= r_cnt - 4'd1;
      else             r_res <= exu_alu_res;
    end
  end

  assign exu_alu_srca  = r_srca;
  assign exu_alu_srcb  = r_srcb;
  assign exu_alu_ctrl  = r_ctrl;
  assign exu_data_reg1 = r_rs1;
  assign exu_data_reg2 = r_rs2;
  assign exu_ext_imm   = r_imm;
  assign exu_pc_val    = r_pc;

  assign out_valid   = (r_state == DONE);
  assign out_res     = r_res;
  assign out_rd      = r_rd;
  assign out_wen     = r_wen;
  assign out_pc      = r_pc;
  assign out_illegal = r_illegal;
  assign busy        = (r_state != IDLE);

`ifdef EXU_PERF_EN
  logic w_xfer;
  assign w_xfer = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (w_xfer) perf_ops  <= perf_ops + 32'd1;
      if (busy)   perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exu_ctrl.sv
// Directed bench for exu_ctrl: two instances (EXEC_LAT=1 and 3) sharing payload, reset and flush.
module tb_exu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  srca, srcb;
  logic [3:0]  ctrl;
  logic [31:0] rs1, rs2, imm, pc;
  logic [4:0]  rd;
  logic        wen;

  logic        v1, rdy_o1, rdy_i1;
  logic [1:0]  sa1, sb1;
  logic [3:0]  c1;
  logic [31:0] d1a, d1b, im1, pc1, res1, ores1, opc1;
  logic [4:0]  ord1;
  logic        ov1, owen1, oill1, busy1;

  logic        v3, rdy_o3, rdy_i3;
  logic [1:0]  sa3, sb3;
  logic [3:0]  c3;
  logic [31:0] d3a, d3b, im3, pc3, res3, ores3, opc3;
  logic [4:0]  ord3;
  logic        ov3, owen3, oill3, busy3;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu(input logic [1:0] a_sel, input logic [1:0] b_sel,
                                      input logic [31:0] r1, input logic [31:0] r2,
                                      input logic [31:0] im, input logic [31:0] p);
    logic [31:0] a, b;
    case (a_sel)
      2'b00:   a = r1;
      2'b10:   a = p;
      default: a = '0;
    endcase
    case (b_sel)
      2'b00:   b = r2;
      2'b01:   b = im;
      2'b10:   b = {27'd0, r2[4:0]};
      default: b = '0;
    endcase
    return a + b;
  endfunction

  assign res1 = alu(sa1, sb1, d1a, d1b, im1, pc1);
  assign res3 = alu(sa3, sb3, d3a, d3b, im3, pc3);

  exu_ctrl #(.EXEC_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(v1), .in_ready(rdy_i1),
    .in_alu_srca(srca), .in_alu_srcb(srcb), .in_alu_ctrl(ctrl),
    .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm), .in_pc(pc), .in_rd(rd), .in_wen(wen),
    .exu_alu_srca(sa1), .exu_alu_srcb(sb1), .exu_alu_ctrl(c1),
    .exu_data_reg1(d1a), .exu_data_reg2(d1b), .exu_ext_imm(im1), .exu_pc_val(pc1),
    .exu_alu_res(res1),
    .out_valid(ov1), .out_ready(rdy_o1), .out_res(ores1), .out_rd(ord1),
    .out_wen(owen1), .out_pc(opc1), .out_illegal(oill1), .busy(busy1)
  );

  exu_ctrl #(.EXEC_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(v3), .in_ready(rdy_i3),
    .in_alu_srca(srca), .in_alu_srcb(srcb), .in_alu_ctrl(ctrl),
    .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm), .in_pc(pc), .in_rd(rd), .in_wen(wen),
    .exu_alu_srca(sa3), .exu_alu_srcb(sb3), .exu_alu_ctrl(c3),
    .exu_data_reg1(d3a), .exu_data_reg2(d3b), .exu_ext_imm(im3), .exu_pc_val(pc3),
    .exu_alu_res(res3),
    .out_valid(ov3), .out_ready(rdy_o3), .out_res(ores3), .out_rd(ord3),
    .out_wen(owen3), .out_pc(opc3), .out_illegal(oill3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_op(input logic [1:0] a, input logic [1:0] b, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] im, input logic [31:0] p,
                        input logic [4:0] d, input logic w);
    srca = a; srcb = b; rs1 = r1; rs2 = r2; imm = im; pc = p; rd = d; wen = w; ctrl = 4'h3;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    v1 = 1'b0; v3 = 1'b0; rdy_o1 = 1'b1; rdy_o3 = 1'b1;
    set_op(2'b00, 2'b00, '0, '0, '0, '0, '0, 1'b0);

    // reset state
    step(); step();
    check("rst_out_valid", {31'd0, ov1}, 32'd0);
    check("rst_busy", {31'd0, busy1 | busy3}, 32'd0);
    check("rst_out_res", ores3, 32'd0);
    check("rst_out_wen_ill", {30'd0, owen1, oill1}, 32'd0);
    check("rst_reg1", d1a, 32'd0);
    check("rst_in_ready", {31'd0, rdy_i1}, 32'd1);
    rst_n = 1'b1;
    step();

    // LAT=1 basic op: rs1 + imm
    set_op(2'b00, 2'b01, 32'h10, 32'h0, 32'h5, 32'h0, 5'd3, 1'b1);
    v1 = 1'b1;
    #1 check("s1_in_ready", {31'd0, rdy_i1}, 32'd1);
    step(); v1 = 1'b0;
    set_op(2'b10, 2'b10, 32'hdead, 32'hbeef, 32'h77, 32'h1234, 5'd9, 1'b0);
    check("s1_exec_valid", {31'd0, ov1}, 32'd0);
    check("s1_exec_busy", {31'd0, busy1}, 32'd1);
    check("s1_exec_srcb", {30'd0, sb1}, 32'd1);
    check("s1_exec_reg1", d1a, 32'h10);
    step();
    check("s1_valid", {31'd0, ov1}, 32'd1);
    check("s1_res", ores1, 32'h15);
    check("s1_rd", {27'd0, ord1}, 32'd3);
    check("s1_wen", {31'd0, owen1}, 32'd1);
    step();
    check("s1_idle_valid", {31'd0, ov1}, 32'd0);
    check("s1_idle_busy", {31'd0, busy1}, 32'd0);

    // LAT=3: pc + imm, operands stable through EXEC
    set_op(2'b10, 2'b01, 32'h0, 32'h0, 32'h4, 32'h8000_0000, 5'd1, 1'b1);
    v3 = 1'b1;
    step(); v3 = 1'b0;
    set_op(2'b00, 2'b00, 32'h5, 32'h6, 32'h0, 32'h0, 5'd0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      check("s2_exec_valid", {31'd0, ov3}, 32'd0);
      check("s2_exec_pc", pc3, 32'h8000_0000);
      check("s2_exec_sel", {28'd0, sa3, sb3}, 32'h9);
      check("s2_exec_imm", im3, 32'h4);
      step();
    end
    check("s2_valid", {31'd0, ov3}, 32'd1);
    check("s2_res", ores3, 32'h8000_0004);
    check("s2_pc", opc3, 32'h8000_0000);
    step();
    check("s2_idle", {30'd0, ov3, busy3}, 32'd0);

    // backpressure then same-cycle handoff
    rdy_o1 = 1'b0;
    set_op(2'b00, 2'b00, 32'h7, 32'h9, 32'h0, 32'h40, 5'd5, 1'b1);
    v1 = 1'b1;
    step();
    set_op(2'b00, 2'b10, 32'h100, 32'h23, 32'h0, 32'h44, 5'd6, 1'b1);
    check("s3_exec_in_ready", {31'd0, rdy_i1}, 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      check("s3_hold_valid", {31'd0, ov1}, 32'd1);
      check("s3_hold_res", ores1, 32'h10);
      check("s3_hold_rd", {27'd0, ord1}, 32'd5);
      check("s3_hold_in_ready", {31'd0, rdy_i1}, 32'd0);
      step();
    end
    rdy_o1 = 1'b1;
    #1 check("s3_b2b_in_ready", {31'd0, rdy_i1}, 32'd1);
    step(); v1 = 1'b0;
    check("s3_b2b_exec", {30'd0, ov1, busy1}, 32'd1);
    check("s3_b2b_reg1", d1a, 32'h100);
    step();
    check("s3_b2b_valid", {31'd0, ov1}, 32'd1);
    check("s3_b2b_res", ores1, 32'h103);
    check("s3_b2b_rd", {27'd0, ord1}, 32'd6);
    check("s3_b2b_pc", opc1, 32'h44);
    step();

    // illegal srcb
    set_op(2'b00, 2'b11, 32'h20, 32'h1, 32'h99, 32'h0, 5'd7, 1'b1);
    v1 = 1'b1;
    step(); v1 = 1'b0;
    check("s4_exec_srcb", {30'd0, sb1}, 32'd0);
    step();
    check("s4_valid", {31'd0, ov1}, 32'd1);
    check("s4_illegal", {31'd0, oill1}, 32'd1);
    check("s4_wen", {31'd0, owen1}, 32'd0);
    check("s4_res", ores1, 32'h21);
    step();

    // flush during EXEC (LAT=3)
    set_op(2'b00, 2'b01, 32'h1, 32'h0, 32'h1, 32'h0, 5'd2, 1'b1);
    v3 = 1'b1;
    step(); v3 = 1'b0;
    flush = 1'b1;
    #1 check("s5_flush_in_ready", {30'd0, rdy_i1, rdy_i3}, 32'd0);
    step(); flush = 1'b0;
    check("s5_flushed", {30'd0, ov3, busy3}, 32'd0);
    step(); step(); step();
    check("s5_stays_idle", {30'd0, ov3, busy3}, 32'd0);

    // flush in DONE with out_ready=1 and a pending op
    rdy_o1 = 1'b0;
    set_op(2'b00, 2'b00, 32'h2, 32'h3, 32'h0, 32'h0, 5'd4, 1'b1);
    v1 = 1'b1;
    step(); v1 = 1'b0;
    step();
    check("s6_done_valid", {31'd0, ov1}, 32'd1);
    rdy_o1 = 1'b1; flush = 1'b1; v1 = 1'b1;
    #1 check("s6_flush_in_ready", {31'd0, rdy_i1}, 32'd0);
    step(); flush = 1'b0; v1 = 1'b0;
    check("s6_flushed", {30'd0, ov1, busy1}, 32'd0);
    step();
    check("s6_no_accept", {31'd0, busy1}, 32'd0);

    // async reset mid-EXEC, then a clean op
    set_op(2'b10, 2'b01, 32'h0, 32'h0, 32'h8, 32'h1000, 5'd8, 1'b1);
    v3 = 1'b1;
    step(); v3 = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("s7_rst_busy", {31'd0, busy3}, 32'd0);
    check("s7_rst_pc", pc3, 32'd0);
    check("s7_rst_wen", {31'd0, owen3}, 32'd0);
    step(); rst_n = 1'b1;
    set_op(2'b00, 2'b01, 32'h1, 32'h0, 32'h2, 32'h0, 5'd10, 1'b1);
    v3 = 1'b1;
    step(); v3 = 1'b0;
    step(); step();
    check("s7_exec_valid", {31'd0, ov3}, 32'd0);
    step();
    check("s7_valid", {31'd0, ov3}, 32'd1);
    check("s7_res", ores3, 32'h3);
    check("s7_rd", {27'd0, ord3}, 32'd10);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
